// File: rtl/branch_train_sequencer.sv
// Branch predictor training sequencer: in-order queue of outstanding predictions,
// one registered training beat per resolve, single-cycle recovery after mispredict/flush.
module branch_train_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PCW   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     allocValid,
  input  logic [PCW-1:0]           allocPC,
  input  logic [2:0]               allocType,
  input  logic                     allocTaken,
  output logic                     allocReady,
  input  logic                     resolveValid,
  input  logic                     resolveTaken,
  input  logic                     flush,
  output logic                     trainValid,
  output logic [PCW-1:0]           trainPC,
  output logic [2:0]               trainType,
  output logic                     trainTaken,
  output logic                     trainMispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              mispredictCount,
  output logic [15:0]              orphanCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {Idle, Track, Recover} stateT;

  stateT stateQ, stateD;
  logic [AW-1:0] headQ, headD, tailQ, tailD;
  logic [AW:0] countQ, countD;
  logic [15:0] misCntQ, misCntD, orphCntQ, orphCntD;
  logic trainValidQ, trainValidD, trainTakenQ, trainTakenD, trainMisQ, trainMisD;
  logic [PCW-1:0] trainPCQ, trainPCD;
  logic [2:0] trainTypeQ, trainTypeD;

  logic [PCW-1:0] pcMem [DEPTH];
  logic [2:0]     typeMem [DEPTH];
  logic           takenMem [DEPTH];

  logic allocAcc, isMis;

  // Readiness comes from registered state only, so a same-cycle pop never frees a full queue.
  assign allocReady = (stateQ != Recover) && (countQ < DepthC);
  assign allocAcc   = allocValid && allocReady;
  assign isMis      = takenMem[headQ] != resolveTaken;

  always_comb begin
    stateD      = stateQ;
    headD       = headQ;
    tailD       = tailQ;
    countD      = countQ;
    misCntD     = misCntQ;
    orphCntD    = orphCntQ;
    trainValidD = 1'b0;
    trainPCD    = trainPCQ;
    trainTypeD  = trainTypeQ;
    trainTakenD = trainTakenQ;
    trainMisD   = trainMisQ;
    if (flush) begin
      headD  = '0;
      tailD  = '0;
      countD = '0;
      stateD = Recover;
    end else begin
      if (allocAcc) begin
        tailD  = tailQ + AW'(1);
        countD = countQ + (AW+1)'(1);
      end
      case (stateQ)
        Idle: begin
          if (resolveValid && orphCntQ != 16'hFFFF) orphCntD = orphCntQ + 16'd1;
          if (allocAcc) stateD = Track;
        end
        Track: begin
          if (resolveValid) begin
            trainValidD = 1'b1;
            trainPCD    = pcMem[headQ];
            trainTypeD  = typeMem[headQ];
            trainTakenD = resolveTaken;
            trainMisD   = isMis;
            if (isMis) begin
              // Younger entries and any same-cycle alloc are wrong-path.
              headD  = '0;
              tailD  = '0;
              countD = '0;
              stateD = Recover;
              if (misCntQ != 16'hFFFF) misCntD = misCntQ + 16'd1;
            end else begin
              headD  = headQ + AW'(1);
              countD = countQ - (AW+1)'(1) + {{AW{1'b0}}, allocAcc};
              if (countD == '0) stateD = Idle;
            end
          end
        end
        Recover: begin
          stateD = Idle;
          if (resolveValid && orphCntQ != 16'hFFFF) orphCntD = orphCntQ + 16'd1;
        end
        default: stateD = Idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ      <= Idle;
      headQ       <= '0;
      tailQ       <= '0;
      countQ      <= '0;
      misCntQ     <= '0;
      orphCntQ    <= '0;
      trainValidQ <= 1'b0;
      trainPCQ    <= '0;
      trainTypeQ  <= '0;
      trainTakenQ <= 1'b0;
      trainMisQ   <= 1'b0;
    end else begin
      stateQ      <= stateD;
      headQ       <= headD;
      tailQ       <= tailD;
      countQ      <= countD;
      misCntQ     <= misCntD;
      orphCntQ    <= orphCntD;
      trainValidQ <= trainValidD;
      trainPCQ    <= trainPCD;
      trainTypeQ  <= trainTypeD;
      trainTakenQ <= trainTakenD;
      trainMisQ   <= trainMisD;
    end
  end

  always_ff @(posedge clk) begin
    if (allocAcc) begin
      pcMem[tailQ]    <= allocPC;
      typeMem[tailQ]  <= allocType;
      takenMem[tailQ] <= allocTaken;
    end
  end

  assign trainValid      = trainValidQ;
  assign trainPC         = trainPCQ;
  assign trainType       = trainTypeQ;
  assign trainTaken      = trainTakenQ;
  assign trainMispredict = trainMisQ;
  assign occupancy       = countQ;
  assign mispredictCount = misCntQ;
  assign orphanCount     = orphCntQ;

endmodule

// File: tb/tb_branch_train_sequencer.sv
// Randomized + directed bench for branch_train_sequencer against a queue-based reference model.
module tb_branch_train_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PCW   = 32;

  logic clk = 1'b0;
  logic reset, allocValid, allocTaken, allocReady, resolveValid, resolveTaken, flush;
  logic [PCW-1:0] allocPC, trainPC;
  logic [2:0] allocType, trainType;
  logic trainValid, trainTaken, trainMispredict;
  logic [$clog2(DEPTH):0] occupancy;
  logic [15:0] mispredictCount, orphanCount;

  branch_train_sequencer #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .reset(reset),
    .allocValid(allocValid), .allocPC(allocPC), .allocType(allocType),
    .allocTaken(allocTaken), .allocReady(allocReady),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken), .flush(flush),
    .trainValid(trainValid), .trainPC(trainPC), .trainType(trainType),
    .trainTaken(trainTaken), .trainMispredict(trainMispredict),
    .occupancy(occupancy), .mispredictCount(mispredictCount), .orphanCount(orphanCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ty;
    logic        tk;
  } entryT;

  entryT q[$];
  logic inRecover = 1'b0;
  logic eValid = 0, eTaken = 0, eMis = 0;
  logic [31:0] ePC = 0;
  logic [2:0] eType = 0;
  int unsigned eMisCnt = 0, eOrphCnt = 0;
  int checks = 0, errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic rst, input logic av, input logic [31:0] pc,
                      input logic [2:0] ty, input logic tk, input logic rv,
                      input logic rt, input logic fl);
    logic ready, acc, mis;
    entryT e;
    reset = rst; allocValid = av; allocPC = pc; allocType = ty; allocTaken = tk;
    resolveValid = rv; resolveTaken = rt; flush = fl;
    ready = !inRecover && (q.size() < DEPTH);
    acc = av && ready;
    mis = 1'b0;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete(); inRecover = 0; eValid = 0; ePC = 0; eType = 0; eTaken = 0; eMis = 0;
      eMisCnt = 0; eOrphCnt = 0;
    end else if (fl) begin
      q.delete(); inRecover = 1; eValid = 0;
    end else begin
      eValid = 0;
      if (rv) begin
        if (!inRecover && q.size() > 0) begin
          e = q.pop_front();
          eValid = 1; ePC = e.pc; eType = e.ty; eTaken = rt; eMis = (e.tk != rt);
          if (eMis) begin
            mis = 1; q.delete();
            if (eMisCnt < 16'hFFFF) eMisCnt++;
          end
        end else if (eOrphCnt < 16'hFFFF) eOrphCnt++;
      end
      if (acc && !mis) q.push_back('{pc: pc, ty: ty, tk: tk});
      inRecover = mis;
    end
    checkEq("allocReady", 32'(allocReady), 32'(!inRecover && q.size() < DEPTH));
    checkEq("trainValid", 32'(trainValid), 32'(eValid));
    checkEq("trainPC", trainPC, ePC);
    checkEq("trainType", 32'(trainType), 32'(eType));
    checkEq("trainTaken", 32'(trainTaken), 32'(eTaken));
    checkEq("trainMispredict", 32'(trainMispredict), 32'(eMis));
    checkEq("occupancy", 32'(occupancy), q.size());
    checkEq("mispredictCount", 32'(mispredictCount), eMisCnt);
    checkEq("orphanCount", 32'(orphanCount), eOrphCnt);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic rt;
    doReset();
    checkEq("resetReady", 32'(allocReady), 1);
    checkEq("resetOcc", 32'(occupancy), 0);

    // In-order correct resolves.
    step(1, 1, 32'h100, 3'd0, 1, 0, 0, 0);
    step(1, 1, 32'h104, 3'd1, 0, 0, 0, 0);
    step(1, 1, 32'h108, 3'd4, 1, 0, 0, 0);
    checkEq("threeOcc", 32'(occupancy), 3);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    checkEq("beat0PC", trainPC, 32'h100);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    checkEq("beat1PC", trainPC, 32'h104);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    checkEq("beat2PC", trainPC, 32'h108);
    checkEq("emptyOcc", 32'(occupancy), 0);
    idle();

    // Fill past capacity, then alloc+resolve while full.
    doReset();
    for (int i = 0; i < 5; i++) step(1, 1, 32'h200 + 32'(4 * i), 3'(i), 0, 0, 0, 0);
    checkEq("fullOcc", 32'(occupancy), 4);
    checkEq("fullReady", 32'(allocReady), 0);
    step(1, 1, 32'h300, 3'd2, 1, 1, 0, 0);
    checkEq("fullPopOcc", 32'(occupancy), 3);
    idle();

    // Mispredict with a same-cycle alloc.
    doReset();
    for (int i = 0; i < 3; i++) step(1, 1, 32'h400 + 32'(4 * i), 3'd5, 1, 0, 0, 0);
    step(1, 1, 32'h500, 3'd1, 1, 1, 0, 0);
    checkEq("misFlag", 32'(trainMispredict), 1);
    checkEq("misCount", 32'(mispredictCount), 1);
    checkEq("misReadyLow", 32'(allocReady), 0);
    idle();
    checkEq("misReadyHigh", 32'(allocReady), 1);

    // Orphan resolves.
    doReset();
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    checkEq("orphans", 32'(orphanCount), 2);
    idle();

    // Flush with a concurrent resolve.
    doReset();
    step(1, 1, 32'h600, 3'd0, 1, 0, 0, 0);
    step(1, 1, 32'h604, 3'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    checkEq("flushNoBeat", 32'(trainValid), 0);
    idle();

    // Wrap-around with overlapped alloc/resolve, then reset mid-stream.
    doReset();
    step(1, 1, 32'h1000, 3'd3, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 1, 32'h1000 + 32'(4 * i), 3'd3, 1, 1, 1, 0);
    checkEq("wrapLastPC", trainPC, 32'h1024);
    step(1, 1, 32'h2000, 3'd3, 1, 1, 1, 0);
    doReset();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rt = $urandom_range(1);
      if (q.size() > 0) rt = ($urandom_range(4) == 0) ? !q[0].tk : q[0].tk;
      step(($urandom_range(199) != 0), ($urandom_range(9) < 6), $urandom, 3'($urandom),
           1'($urandom), ($urandom_range(1) == 1), rt, ($urandom_range(39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
